// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: bundles the requester side (req/dir/presets, gnt/done/busy)
// and the shared up/down counter control side (load/enable/up_down/data_in,
// count feedback) of the counter_arbiter.
//   slave  : the arbiter itself (consumes requests and count, drives grants and counter controls)
//   master : the environment (requesters plus the physical counter)
interface counter_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [WIDTH-1:0] preset0;
    logic [WIDTH-1:0] preset1;
    logic [WIDTH-1:0] cnt_value;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             cnt_load;
    logic             cnt_enable;
    logic             cnt_up_down;
    logic [WIDTH-1:0] cnt_data_in;

    modport slave (
        input  req, dir, preset0, preset1, cnt_value,
        output gnt, done, busy, cnt_load, cnt_enable, cnt_up_down, cnt_data_in
    );

    modport master (
        output req, dir, preset0, preset1, cnt_value,
        input  gnt, done, busy, cnt_load, cnt_enable, cnt_up_down, cnt_data_in
    );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sequencer sharing one WIDTH-bit up/down counter
// between two requesters. The winner's preset is loaded, the counter runs to
// the terminal value (all-ones up, zero down) and the winner gets a done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - counter_arbiter_if.slave: req/dir/preset0/preset1/cnt_value in,
//          gnt/done/busy/cnt_load/cnt_enable/cnt_up_down/cnt_data_in out
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    counter_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic             ptr_r;
    logic             owner_r;
    logic [1:0]       gnt_r;
    logic [1:0]       done_r;
    logic             busy_r;
    logic             load_r;
    // The latched dir/preset double as the counter's up_down/data_in drivers.
    logic             up_r;
    logic [WIDTH-1:0] data_r;

    logic             winner_s;
    logic [WIDTH-1:0] win_preset_s;
    logic             win_dir_s;
    logic [WIDTH-1:0] terminal_s;
    logic             at_term_s;
    logic             owner_req_s;
    logic             enable_s;

    // Arbitration: a lone request wins outright; a tie goes to the pointer.
    always_comb begin
        winner_s = 1'b0;
        if (bus.req == 2'b11) begin
            winner_s = ptr_r;
        end else if (bus.req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        if (winner_s) begin
            win_preset_s = bus.preset1;
        end else begin
            win_preset_s = bus.preset0;
        end
        win_dir_s = bus.dir[winner_s];
    end

    // Terminal detection and count enable; enable is combinational on the
    // count so the counter stops exactly at terminal and never wraps.
    always_comb begin
        if (up_r) begin
            terminal_s = {WIDTH{1'b1}};
        end else begin
            terminal_s = {WIDTH{1'b0}};
        end
        at_term_s   = (bus.cnt_value == terminal_s);
        owner_req_s = bus.req[owner_r];
        if ((state_r == RUN) && owner_req_s && !at_term_s) begin
            enable_s = 1'b1;
        end else begin
            enable_s = 1'b0;
        end
    end

    // Sequencer FSM with all registered outputs updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
            load_r  <= 1'b0;
            up_r    <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 2'b00;
                    if (|bus.req) begin
                        state_r <= LOAD;
                        owner_r <= winner_s;
                        gnt_r   <= winner_s ? 2'b10 : 2'b01;
                        busy_r  <= 1'b1;
                        load_r  <= 1'b1;
                        data_r  <= win_preset_s;
                        up_r    <= win_dir_s;
                    end else begin
                        gnt_r  <= 2'b00;
                        busy_r <= 1'b0;
                        load_r <= 1'b0;
                    end
                end
                LOAD: begin
                    load_r  <= 1'b0;
                    state_r <= RUN;
                end
                RUN: begin
                    if (at_term_s) begin
                        state_r <= DONE;
                        done_r  <= gnt_r;
                    end else if (!owner_req_s) begin
                        // Abandoned job: no done pulse, pointer untouched.
                        state_r <= IDLE;
                        gnt_r   <= 2'b00;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 2'b00;
                    gnt_r   <= 2'b00;
                    busy_r  <= 1'b0;
                    ptr_r   <= ~owner_r;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 2'b00;
                    gnt_r   <= 2'b00;
                    busy_r  <= 1'b0;
                    load_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    assign bus.cnt_load    = load_r;
    assign bus.cnt_enable  = enable_s;
    assign bus.cnt_up_down = up_r;
    assign bus.cnt_data_in = data_r;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: self-checking bench for counter_arbiter. Models the
// shared up/down counter, applies a table of single jobs through a scoreboard
// queue, then runs hand-written abandon, alternation and mid-run reset sequences.
module tb_counter_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_arbiter_if #(.WIDTH(W)) bus ();
    counter_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Behavioural model of the shared counter driven by the arbiter.
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (bus.cnt_load) count <= bus.cnt_data_in;
        else if (bus.cnt_enable) count <= bus.cnt_up_down ? count + 4'd1 : count - 4'd1;
    end
    assign bus.cnt_value = count;

    typedef struct {
        logic [1:0] req;
        logic [1:0] dir;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [1:0] gnt;
        int         n;
        logic [3:0] fin;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        int         n;
        int         done_cyc;
        logic [3:0] fin;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
        end
    endtask

    // Runs one job from a mid-cycle IDLE point; ends mid-cycle in the following IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   n_en;
        int   gnt_bad;
        int   c;
        bit   seen;
        logic [3:0] pexp;
        bus.req = v.req; bus.dir = v.dir; bus.preset0 = v.p0; bus.preset1 = v.p1;
        e.gnt = v.gnt; e.n = v.n; e.done_cyc = 3 + v.n; e.fin = v.fin;
        sbq.push_back(e);
        pexp = v.gnt[1] ? v.p1 : v.p0;
        n_en = 0; gnt_bad = 0; seen = 1'b0; c = 0;
        got.gnt = 2'b00; got.n = 0; got.done_cyc = -1; got.fin = 4'd0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                got.gnt = bus.gnt;
                check($sformatf("v%0d_load", idx), int'(bus.cnt_load), 1);
            end
            if (c == 2) check($sformatf("v%0d_preset_held", idx), int'(count), int'(pexp));
            if (bus.cnt_enable) n_en++;
            if (bus.gnt !== v.gnt) gnt_bad++;
            if (bus.done != 2'b00) begin
                seen = 1'b1;
                got.done_cyc = c;
                got.fin = count;
                check($sformatf("v%0d_done_bits", idx), int'(bus.done), int'(v.gnt));
                bus.req = 2'b00;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: actual no done required done", idx);
            bus.req = 2'b00;
        end
        e = sbq.pop_front();
        check($sformatf("v%0d_gnt", idx), int'(got.gnt), int'(e.gnt));
        check($sformatf("v%0d_enables", idx), n_en, e.n);
        check($sformatf("v%0d_done_cycle", idx), got.done_cyc, e.done_cyc);
        check($sformatf("v%0d_final_count", idx), int'(got.fin), int'(e.fin));
        check($sformatf("v%0d_gnt_held", idx), gnt_bad, 0);
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), int'(bus.busy), 0);
        check($sformatf("v%0d_idle_gnt", idx), int'(bus.gnt), 0);
    endtask

    vec_t vecs[9];

    initial begin
        // req    dir    p0      p1      gnt    n  final
        vecs[0] = '{2'b01, 2'b00, 4'd3,  4'd0,  2'b01, 3, 4'd0};
        vecs[1] = '{2'b10, 2'b10, 4'd0,  4'd14, 2'b10, 1, 4'd15};
        vecs[2] = '{2'b01, 2'b00, 4'd0,  4'd0,  2'b01, 0, 4'd0};
        vecs[3] = '{2'b11, 2'b01, 4'd5,  4'd6,  2'b10, 6, 4'd0};
        vecs[4] = '{2'b11, 2'b01, 4'd12, 4'd6,  2'b01, 3, 4'd15};
        vecs[5] = '{2'b10, 2'b00, 4'd0,  4'd2,  2'b10, 2, 4'd0};
        vecs[6] = '{2'b10, 2'b10, 4'd0,  4'd15, 2'b10, 0, 4'd15};
        vecs[7] = '{2'b01, 2'b01, 4'd15, 4'd0,  2'b01, 0, 4'd15};
        vecs[8] = '{2'b10, 2'b00, 4'd0,  4'd1,  2'b10, 1, 4'd0};

        rst = 1'b0;
        bus.req = 2'b00; bus.dir = 2'b00; bus.preset0 = 4'd0; bus.preset1 = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_gnt", int'(bus.gnt), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_data_in", int'(bus.cnt_data_in), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Abandon: req0 counting 9 down, dropped when the count shows 5.
        begin
            int  c;
            bit  dropped;
            int  done_seen;
            bus.req = 2'b01; bus.dir = 2'b00; bus.preset0 = 4'd9;
            c = 0; dropped = 1'b0; done_seen = 0;
            while (!dropped && c < 20) begin
                @(negedge clk);
                c++;
                if (bus.done != 2'b00) done_seen++;
                if (c == 3) begin
                    bus.preset0 = 4'd1; bus.dir = 2'b11;
                    #1;
                    check("latch_dir", int'(bus.cnt_up_down), 0);
                    check("latch_preset", int'(bus.cnt_data_in), 9);
                end
                if (count == 4'd5 && c >= 2) begin
                    check("abandon_cycle", c, 6);
                    bus.req = 2'b00;
                    #1;
                    check("abandon_enable", int'(bus.cnt_enable), 0);
                    dropped = 1'b1;
                end
            end
            check("abandon_reached", int'(dropped), 1);
            @(negedge clk);
            if (bus.done != 2'b00) done_seen++;
            check("abandon_no_done", done_seen, 0);
            check("abandon_idle_busy", int'(bus.busy), 0);
            check("abandon_count_frozen", int'(count), 5);
        end

        // Alternation: req=11 held, requester 0 must win first after the abandon.
        begin
            logic [1:0] g;
            logic [1:0] prev;
            int         gap;
            int         ngr;
            exp_t       e;
            exp_t       x;
            bus.req = 2'b11; bus.dir = 2'b10; bus.preset0 = 4'd2; bus.preset1 = 4'd13;
            x.n = 2; x.done_cyc = 5; x.fin = 4'd0;
            x.gnt = 2'b01; sbq.push_back(x);
            x.gnt = 2'b10; sbq.push_back(x);
            x.gnt = 2'b01; sbq.push_back(x);
            x.gnt = 2'b10; sbq.push_back(x);
            prev = 2'b00; gap = 0; ngr = 0;
            for (int c = 0; c < 40 && ngr < 4; c++) begin
                @(negedge clk);
                g = bus.gnt;
                check("alt_onehot", int'(g == 2'b11), 0);
                if (bus.done != 2'b00) check("alt_done_owner", int'(bus.done), int'(g));
                if (g != 2'b00 && prev != 2'b00 && g != prev) check("alt_overlap", int'(g), int'(prev));
                if (g != 2'b00 && prev == 2'b00) begin
                    e = sbq.pop_front();
                    check("alt_gnt", int'(g), int'(e.gnt));
                    if (ngr > 0) check("alt_gap", gap, 1);
                    ngr++;
                end
                if (g == 2'b00) gap++;
                else gap = 0;
                prev = g;
            end
            check("alt_grants", ngr, 4);
            bus.req = 2'b00;
            for (int c = 0; c < 10 && bus.busy; c++) @(negedge clk);
            check("alt_drained", int'(bus.busy), 0);
            @(negedge clk);
        end

        // Reset mid-RUN: outputs clear asynchronously; pointer returns to 0.
        begin
            bus.req = 2'b01; bus.dir = 2'b01; bus.preset0 = 4'd3;
            repeat (4) @(negedge clk);
            check("pre_reset_gnt", int'(bus.gnt), 1);
            check("pre_reset_up", int'(bus.cnt_up_down), 1);
            #2;
            rst = 1'b0;
            bus.req = 2'b11;
            #1;
            check("rst_gnt", int'(bus.gnt), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_load", int'(bus.cnt_load), 0);
            check("rst_enable", int'(bus.cnt_enable), 0);
            check("rst_up_down", int'(bus.cnt_up_down), 0);
            check("rst_data_in", int'(bus.cnt_data_in), 0);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("post_rst_gnt", int'(bus.gnt), 1);
            bus.req = 2'b00;
            repeat (3) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Sequencer and round-robin arbiter that shares one WIDTH-bit up/down counter between two requesters. Each requester supplies a preset and a direction. The block grants the counter to one requester, loads the preset, and counts to the terminal value (all-ones when counting up, zero when counting down). It then pulses that requester's done flag. The block drives the counter's load/enable/up_down/data_in controls and observes its count_out; the counter's co output is not used.

## Interface
- WIDTH, 4, counter and preset width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req  input  2  per-requester level request; held until done or abandoned
- dir  input  2  per-requester direction, 1 = up, 0 = down
- preset0  input  WIDTH  requester 0 start value
- preset1  input  WIDTH  requester 1 start value
- cnt_value  input  WIDTH  counter count_out
- gnt  output  2  one-hot grant, registered
- done  output  2  one-cycle completion pulse to granted requester, registered
- busy  output  1  high in any state other than IDLE
- cnt_load  output  1  counter load
- cnt_enable  output  1  counter enable
- cnt_up_down  output  1  counter direction
- cnt_data_in  output  WIDTH  counter load data

## Operation
- States and transitions:
  - IDLE: if any req is high, pick a winner, latch its preset/dir, then go to LOAD.
  - LOAD: go to RUN.
  - RUN: go to DONE when cnt_value == terminal; go to IDLE when the granted req drops; otherwise stay.
  - DONE: go to IDLE.
- Arbitration:
  - One priority pointer; reset value selects requester 0.
  - With a single request, that requester wins.
  - With both requests, the pointer's requester wins.
  - The pointer moves to the other requester on DONE only. An abandoned job leaves the pointer unchanged.
- Latching: preset and dir are captured on the IDLE→LOAD edge. Later changes are ignored until the next grant.
- gnt: high from LOAD through DONE inclusive; 0 in IDLE.
- LOAD cycle: cnt_load=1, cnt_data_in=latched preset, cnt_enable=0.
- RUN cycle:
  - cnt_up_down = latched dir.
  - cnt_enable = 1 iff cnt_value != terminal. This is combinational on cnt_value, so the counter never wraps.
- Terminal value: {WIDTH{1'b1}} when dir=1, 0 when dir=0.
- Enable-cycle count: preset when counting down; (2^WIDTH−1−preset) when counting up. Zero if the preset already equals the terminal value.
- done[g]: high for exactly the DONE cycle. done is never high for the non-granted requester.
- Idle outputs: cnt_load=cnt_enable=0. cnt_data_in and cnt_up_down hold their latched values.
- Abandon: granted req low during RUN → cnt_enable=0 that same cycle, no done, go to IDLE. A req drop during LOAD is handled in the first RUN cycle.
- Reset (any time, including mid-RUN):
  - State returns to IDLE; pointer returns to requester 0.
  - gnt=0, done=0, busy=0, cnt_load=0, cnt_enable=0, cnt_up_down=0, cnt_data_in=0, latched preset/dir=0.

## Timing
- Cycle 0 is the first cycle req is high in IDLE. LOAD is cycle 1 and RUN starts in cycle 2.
- The counter holds the preset from cycle 2. Terminal is detected in cycle 2+N, where N is the enable-cycle count. DONE (done pulse) is in cycle 3+N; IDLE is in cycle 4+N.
- A request that is still pending is granted on the next IDLE cycle, so there is one idle cycle between jobs.
- All state, gnt, done, busy, and latched registers update on the rising clk edge or asynchronously clear on rst falling.

## Test plan
- Simple down count:
  - Stimulus: WIDTH=4; req0=1, dir0=0, preset0=3 after reset.
  - Required: cnt_value 3,2,1,0 in cycles 2–5; cnt_enable high in cycles 2–4; done[0] high only in cycle 6; gnt=01 in cycles 1–6.
- Simultaneous requests:
  - Stimulus: req=11 from reset and held, re-requesting after each done.
  - Required: grants alternate 01, 10, 01, …; no overlap; one IDLE cycle between jobs.
- Up count near the top:
  - Stimulus: req1, dir1=1, preset1=14.
  - Required: exactly 1 enable cycle; cnt_value 14 then 15; done[1] in cycle 4; no wrap to 0.
- Preset already at terminal:
  - Stimulus: req0, dir0=0, preset0=0.
  - Required: zero enable cycles; done[0] in cycle 3.
- Abandoned job:
  - Stimulus: req0, preset0=9, down; drop req0 in the RUN cycle where cnt_value=5.
  - Required: cnt_enable=0 that cycle; no done pulse; IDLE next; with req=11 afterwards, requester 0 is granted again.
- Reset mid-RUN:
  - Stimulus: rst low mid-RUN.
  - Required: all outputs 0 immediately, without waiting for a clk edge; after release, req=11 grants requester 0 first.
